// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 frame receiver with key press/release tracking and 7-seg nibbles; define PS2_KEY_COUNT_EN to build the press counter
module ps2_key_tracker #(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic [7:0] key_count,
  output logic       disp_en,
  output logic [3:0] code_lo,
  output logic [3:0] code_hi,
  output logic [3:0] cnt_lo,
  output logic [3:0] cnt_hi,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [2:0] c_sync, d_sync;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, rx_byte;
  logic [TW-1:0] tmo;
  logic par_bit, break_pend;
  logic fall, bit_in, tmo_hit, frame_ok, stop_edge, new_press;
  assign fall      = c_sync[2] & ~c_sync[1];
  assign bit_in    = d_sync[1];
  assign tmo_hit   = state != IDLE && !fall && tmo == TW'(TIMEOUT_CYC - 1);
  assign frame_ok  = bit_in & (^{shreg, par_bit});
  assign stop_edge = fall && state == STOP;
  assign new_press = byte_valid && rx_byte != 8'hE0 && rx_byte != 8'hF0 && !break_pend &&
                     (!disp_en || rx_byte != key_code);
  // next frame state: only a falling edge advances, timeout aborts to IDLE
  always_comb begin
    state_n = tmo_hit ? IDLE :
              !fall ? state :
              state == IDLE ? (bit_in ? IDLE : DATA) :
              state == DATA ? (bit_cnt == 3'd7 ? PARITY : DATA) :
              state == PARITY ? STOP : IDLE;
  end
  // synchronizers, frame shift/parity capture, timeout and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync     <= '1;
      d_sync     <= '1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo        <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      c_sync     <= {c_sync[1:0], ps2_clk};
      d_sync     <= {d_sync[1:0], ps2_data};
      state      <= state_n;
      tmo        <= (state == IDLE || fall || tmo_hit) ? '0 : tmo + 1'b1;
      byte_valid <= stop_edge && frame_ok;
      frame_err  <= tmo_hit || (stop_edge && !frame_ok);
      if (tmo_hit || (fall && state == IDLE)) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (fall && state == DATA) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {bit_in, shreg[7:1]};
      end
      if (fall && state == PARITY) par_bit <= bit_in;
      if (stop_edge) rx_byte <= shreg;
    end
  end
  // key state: break prefix, release of the held key, new presses
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code   <= '0;
      disp_en    <= 1'b0;
      break_pend <= 1'b0;
    end else if (byte_valid && rx_byte == 8'hF0) begin
      break_pend <= 1'b1;
    end else if (byte_valid && rx_byte != 8'hE0 && break_pend) begin
      break_pend <= 1'b0;
      if (rx_byte == key_code) disp_en <= 1'b0;
    end else if (new_press) begin
      key_code <= rx_byte;
      disp_en  <= 1'b1;
    end
  end
`ifdef PS2_KEY_COUNT_EN
  logic [7:0] cnt_q;
  // press counter, wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (new_press) cnt_q <= cnt_q + 1'b1;
  end
  assign key_count = cnt_q;
`else
  assign key_count = 8'd0;
`endif
  assign code_lo = key_code[3:0];
  assign code_hi = key_code[7:4];
  assign cnt_lo  = key_count[3:0];
  assign cnt_hi  = key_count[7:4];
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed PS/2 frame scenarios against hand-computed key state
module tb_ps2_key_tracker;
  localparam int TMO = 200;
  localparam int H = 3;
`ifdef PS2_KEY_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] key_code, key_count;
  logic disp_en, byte_valid, frame_err;
  logic [3:0] code_lo, code_hi, cnt_lo, cnt_hi;
  int total = 0, bad = 0, nbv = 0, nerr = 0;

  ps2_key_tracker #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_count(key_count), .disp_en(disp_en),
    .code_lo(code_lo), .code_hi(code_hi), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi),
    .byte_valid(byte_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) nbv++;
    if (frame_err) nerr++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(8);
  endtask

  task automatic press(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({key_code, key_count, disp_en, byte_valid, frame_err} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got code=%h cnt=%h disp=%b bv=%b err=%b want all 0",
               key_code, key_count, disp_en, byte_valid, frame_err);
    end
  endtask

  task automatic test_press;
    int bv0;
    bv0 = nbv;
    press(8'h1C);
    total++;
    if (nbv - bv0 !== 1) begin bad++; $display("FAIL press_bv: got %0d pulses want 1", nbv - bv0); end
    total++;
    if ({key_code, disp_en} !== {8'h1C, 1'b1}) begin
      bad++; $display("FAIL press_state: got code=%h disp=%b want 1c 1", key_code, disp_en);
    end
    total++;
    if (key_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
      bad++; $display("FAIL press_count: got %h want %h", key_count, CNT_EN ? 8'd1 : 8'd0);
    end
    total++;
    if ({code_hi, code_lo, cnt_hi, cnt_lo} !== {4'h1, 4'hC, 4'h0, CNT_EN ? 4'h1 : 4'h0}) begin
      bad++; $display("FAIL press_nibbles: got %h%h %h%h", code_hi, code_lo, cnt_hi, cnt_lo);
    end
  endtask

  task automatic test_release;
    press(8'hF0);
    total++;
    if (disp_en !== 1'b1) begin bad++; $display("FAIL break_prefix_disp: got %b want 1", disp_en); end
    press(8'h1C);
    total++;
    if ({key_code, key_count, disp_en} !== {8'h1C, CNT_EN ? 8'd1 : 8'd0, 1'b0}) begin
      bad++; $display("FAIL release: got code=%h cnt=%h disp=%b want 1c %h 0",
                      key_code, key_count, disp_en, CNT_EN ? 8'd1 : 8'd0);
    end
  endtask

  task automatic test_typematic;
    do_reset();
    press(8'h1C);
    press(8'h1C);
    press(8'h1C);
    total++;
    if ({key_code, key_count, disp_en} !== {8'h1C, CNT_EN ? 8'd1 : 8'd0, 1'b1}) begin
      bad++; $display("FAIL typematic: got code=%h cnt=%h disp=%b", key_code, key_count, disp_en);
    end
    press(8'h32);
    total++;
    if ({key_code, key_count, disp_en} !== {8'h32, CNT_EN ? 8'd2 : 8'd0, 1'b1}) begin
      bad++; $display("FAIL second_key: got code=%h cnt=%h disp=%b", key_code, key_count, disp_en);
    end
    press(8'hE0);
    total++;
    if ({key_code, key_count, disp_en} !== {8'h32, CNT_EN ? 8'd2 : 8'd0, 1'b1}) begin
      bad++; $display("FAIL e0_ignored: got code=%h cnt=%h disp=%b", key_code, key_count, disp_en);
    end
  endtask

  task automatic test_errors;
    int bv0, e0;
    bv0 = nbv;
    e0 = nerr;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    total++;
    if (nerr - e0 !== 1) begin bad++; $display("FAIL parity_err: got %0d pulses want 1", nerr - e0); end
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    total++;
    if (nerr - e0 !== 2) begin bad++; $display("FAIL stop_err: got %0d pulses want 2", nerr - e0); end
    total++;
    if (nbv - bv0 !== 0) begin bad++; $display("FAIL err_no_bv: got %0d pulses want 0", nbv - bv0); end
    total++;
    if ({key_code, key_count, disp_en} !== {8'h32, CNT_EN ? 8'd2 : 8'd0, 1'b1}) begin
      bad++; $display("FAIL err_unchanged: got code=%h cnt=%h disp=%b", key_code, key_count, disp_en);
    end
  endtask

  task automatic test_timeout;
    int bv0, e0;
    do_reset();
    e0 = nerr;
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    total++;
    if (nerr - e0 !== 0) begin bad++; $display("FAIL early_timeout: got %0d pulses want 0", nerr - e0); end
    wait_cyc(TMO + 20);
    total++;
    if (nerr - e0 !== 1) begin bad++; $display("FAIL timeout_err: got %0d pulses want 1", nerr - e0); end
    bv0 = nbv;
    press(8'h32);
    total++;
    if (nbv - bv0 !== 1 || {key_code, key_count, disp_en} !== {8'h32, CNT_EN ? 8'd1 : 8'd0, 1'b1}) begin
      bad++; $display("FAIL after_timeout: got bv=%0d code=%h cnt=%h disp=%b want 1 32 %h 1",
                      nbv - bv0, key_code, key_count, disp_en, CNT_EN ? 8'd1 : 8'd0);
    end
  endtask

  task automatic test_reset_mid;
    int e0;
    e0 = nerr;
    send_frame(8'h5A, 1'b0, 1'b1, 4);
    rst = 1'b1;
    wait_cyc(2);
    total++;
    if ({key_code, key_count, disp_en, byte_valid, frame_err} !== 19'd0) begin
      bad++; $display("FAIL reset_mid: got code=%h cnt=%h disp=%b want 0", key_code, key_count, disp_en);
    end
    rst = 1'b0;
    wait_cyc(TMO + 20);
    total++;
    if (nerr - e0 !== 0) begin bad++; $display("FAIL reset_mid_err: got %0d pulses want 0", nerr - e0); end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      press(8'h1C);
      press(8'hF0);
      press(8'h1C);
      if (i == 254) begin
        total++;
        if (key_count !== (CNT_EN ? 8'hFF : 8'h00)) begin
          bad++; $display("FAIL count_255: got %h want %h", key_count, CNT_EN ? 8'hFF : 8'h00);
        end
      end
    end
    total++;
    if ({key_count, disp_en, key_code} !== {8'h00, 1'b0, 8'h1C}) begin
      bad++; $display("FAIL count_wrap: got cnt=%h disp=%b code=%h want 00 0 1c", key_count, disp_en, key_code);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_typematic();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
